sbox_out_buffer: RTL and testbench

Output-side stage of the 32-bit masked S-box datapath. Captures the four masked S-box output bytes (bitsliced, d shares per bit) produced by the linear bottom layers when a column issued LATENCY cycles earlier emerges. It injects the affine constant on share 0 and buffers results in a small FIFO. It exposes a valid/ready interface downstream and issues credit-based back-pressure upstream, because the HPC2 S-box pipeline itself cannot stall.

---
 rtl/sbox_out_buffer.sv | 161 ++++++++++++++++
 tb/tb_sbox_out_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_out_buffer
//  Description : Output stage of the 32-bit masked S-box datapath. Tracks
//                columns travelling through the fixed-latency S-box pipeline,
//                captures the bitsliced share vector (D shares per bit) when
//                a column emerges, optionally folds in the AES affine
//                constant on share 0, and buffers results in a small FIFO.
//                Downstream sees valid/ready. Upstream sees credit-based
//                back-pressure, because the S-box pipeline cannot stall.
//
//  Optional    : SBOX_OUT_AFFINE_CONST_EN
//                  defined   -> share 0 of each output byte is XORed with 0x63
//                               on capture.
//                  undefined -> sb_in is stored unmodified.
//
//  Ports       : clk          clock, all state on rising edge
//                rst          asynchronous active-high reset
//                issue_valid  upstream launches a column this cycle
//                issue_ready  credit available (issue legal only when high)
//                sb_in        bottom-layer outputs, bit k shares at [k*D +: D]
//                out_valid    head entry available
//                out_ready    downstream accepts head
//                out_data     head entry, same packing as sb_in
//                occupancy    in-flight + stored entries
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox_out_buffer #(
    parameter int D       = 2,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       issue_valid,
    output logic                            issue_ready,
    input  wire logic [32*D-1:0]            sb_in,
    output logic                            out_valid,
    input  wire logic                       out_ready,
    output logic [32*D-1:0]                 out_data,
    output logic [$clog2(DEPTH):0]          occupancy
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_W        = 32 * D;
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE      = (c_AW + 1)'(1);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                 w_fire;
    logic                 w_capture;
    logic                 w_pop;
    logic [LATENCY-1:0]   r_track;
    logic [c_AW:0]        r_occ;
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic [c_AW:0]        w_count;
    logic [c_W-1:0]       w_capt_data;
    logic [c_W-1:0]       w_head;
    logic [c_W-1:0]       r_mem [DEPTH];

    assign issue_ready = (r_occ < c_DEPTH);
    assign w_fire      = issue_valid & issue_ready;
    assign w_capture   = r_track[LATENCY-1];

    // Extra wrap bit on each pointer lets full and empty be told apart.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign out_valid   = (w_count != '0);
    assign w_pop       = out_valid & out_ready;
    assign occupancy   = r_occ;

    // ------------------------------------------------------------------
    // Tracking shift register: one bit per pipeline stage, the tail bit
    // marks the cycle in which an issued column leaves the bottom layer.
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_track_1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_track <= '0;
                end else begin
                    r_track <= w_fire;
                end
            end
        end else begin : g_track_n
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_track <= '0;
                end else begin
                    r_track <= {r_track[LATENCY-2:0], w_fire};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Capture data path. The constant only ever touches share 0 of each
    // bit so no share index is combined with another.
    // ------------------------------------------------------------------
`ifdef SBOX_OUT_AFFINE_CONST_EN
    localparam logic [7:0] c_AFFINE = 8'h63;

    generate
        for (genvar k = 0; k < 32; k++) begin : g_affine
            assign w_capt_data[k*D] = sb_in[k*D] ^ c_AFFINE[k % 8];
            if (D > 1) begin : g_upper
                assign w_capt_data[k*D+1 +: D-1] = sb_in[k*D+1 +: D-1];
            end
        end
    endgenerate
`else
    assign w_capt_data = sb_in;
`endif

    // ------------------------------------------------------------------
    // Credit counter: counts columns in flight plus columns stored, so a
    // capture can never find the FIFO full.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({w_fire, w_pop})
                2'b10:   r_occ <= r_occ + c_ONE;
                2'b01:   r_occ <= r_occ - c_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= w_capt_data;
                r_wr_ptr                  <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
        end
    end

    // Head read is a per-share mux across entries; the result is forced to
    // zero when nothing is stored so stale shares never leave the block.
    assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign out_data = w_head & {c_W{out_valid}};

endmodule
`default_nettype wire

// File: tb/tb_sbox_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sbox_out_buffer
//  Description : Self-checking bench for sbox_out_buffer with a queue-based
//                reference model (issue times in flight, stored columns).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_out_buffer;

    localparam int D   = 2;
    localparam int L   = 4;
    localparam int DEP = 4;
    localparam int OW  = $clog2(DEP) + 1;
`ifdef SBOX_OUT_AFFINE_CONST_EN
    localparam logic [7:0] c_AFF = 8'h63;
`else
    localparam logic [7:0] c_AFF = 8'h00;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [32*D-1:0]   sb_in;
    logic              out_valid;
    logic              out_ready;
    logic [32*D-1:0]   out_data;
    logic [OW-1:0]     occupancy;

    int errors = 0;
    int checks = 0;

    sbox_out_buffer #(.D(D), .LATENCY(L), .DEPTH(DEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .sb_in       (sb_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: issue cycles of columns still in the pipeline, and
    // the values sitting in the output buffer.
    // ------------------------------------------------------------------
    int              cyc = 0;
    int              inflight_q[$];
    logic [32*D-1:0] fifo_q[$];
    int              ncapt = 0;

    function automatic logic [32*D-1:0] affine(input logic [32*D-1:0] x);
        logic [32*D-1:0] y;
        y = x;
        for (int k = 0; k < 32; k++) y[k*D] = x[k*D] ^ c_AFF[k%8];
        return y;
    endfunction

    function automatic logic [31:0] unmask(input logic [32*D-1:0] x);
        logic [31:0] u;
        u = '0;
        for (int k = 0; k < 32; k++)
            for (int s = 0; s < D; s++) u[k] = u[k] ^ x[k*D+s];
        return u;
    endfunction

    function automatic logic [31:0] share_of(input logic [32*D-1:0] x, input int s);
        logic [31:0] u;
        for (int k = 0; k < 32; k++) u[k] = x[k*D+s];
        return u;
    endfunction

    function automatic logic [32*D-1:0] pack(input logic [31:0] s0, input logic [31:0] s1);
        logic [32*D-1:0] v;
        v = '0;
        for (int k = 0; k < 32; k++) begin
            v[k*D]   = s0[k];
            v[k*D+1] = s1[k];
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] m_occ();
        return OW'(inflight_q.size() + fifo_q.size());
    endfunction
    function automatic logic m_valid();
        return fifo_q.size() != 0;
    endfunction
    function automatic logic m_ready();
        return (inflight_q.size() + fifo_q.size()) < DEP;
    endfunction
    function automatic logic [32*D-1:0] m_data();
        return (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    // One clock cycle: inputs are already stable, update the model on the
    // edge with the same inputs the DUT sees, return at the falling edge.
    task automatic tick();
        bit fire, pop;
        fire = issue_valid && m_ready();
        pop  = m_valid() && out_ready;
        @(posedge clk);
        if (pop) void'(fifo_q.pop_front());
        if (inflight_q.size() != 0 && inflight_q[0] == cyc - L) begin
            void'(inflight_q.pop_front());
            fifo_q.push_back(affine(sb_in));
            ncapt++;
        end
        if (fire) inflight_q.push_back(cyc);
        cyc++;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; sb_in = '0;
        repeat (3) @(negedge clk);
        if (out_valid !== 1'b0 || out_data !== '0 || issue_ready !== 1'b1 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b r=%0b occ=%0d data=%h, want v=0 r=1 occ=0 data=0",
                     out_valid, issue_ready, occupancy, out_data);
        end
        checks++;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sb_in = {$urandom, $urandom};
            tick();
            if (out_valid !== 1'b0 || out_data !== '0 || issue_ready !== 1'b1 || occupancy !== '0) begin
                errors++;
                $display("FAIL idle_cycle %0d: got v=%0b r=%0b occ=%0d data=%h, want v=0 r=1 occ=0 data=0",
                         i, out_valid, issue_ready, occupancy, out_data);
            end
            checks++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        int wait_cyc;
        sb_in = pack(32'hA5A5A5A5, 32'hA5A5A5A5);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wait_cyc = 0;
        while (out_valid !== 1'b1 && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        if (wait_cyc != L) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, want %0d", wait_cyc, L);
        end
        checks++;
        if (unmask(out_data) !== {4{c_AFF}}) begin
            errors++;
            $display("FAIL single_unmasked: got %h, want %h", unmask(out_data), {4{c_AFF}});
        end
        checks++;
        if (share_of(out_data, 1) !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL single_share1: got %h, want a5a5a5a5", share_of(out_data, 1));
        end
        checks++;
        if (out_data !== m_data() || occupancy !== m_occ()) begin
            errors++;
            $display("FAIL single_model: got occ=%0d data=%h, want occ=%0d data=%h",
                     occupancy, out_data, m_occ(), m_data());
        end
        checks++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || occupancy !== '0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_drain: got v=%0b occ=%0d r=%0b, want v=0 occ=0 r=1",
                     out_valid, occupancy, issue_ready);
        end
        checks++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        int nacc;
        logic [7:0] tag;
        nacc = 0; ncapt = 0;
        out_ready = 1'b0; issue_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sb_in = pack({24'h0, 8'(ncapt + 1)}, 32'h0);
            if (issue_ready === 1'b1) nacc++;
            tick();
            if (out_valid !== m_valid() || out_data !== m_data() || issue_ready !== m_ready() || occupancy !== m_occ()) begin
                errors++;
                $display("FAIL bp_fill cycle %0d: got v=%0b r=%0b occ=%0d data=%h, want v=%0b r=%0b occ=%0d data=%h",
                         i, out_valid, issue_ready, occupancy, out_data, m_valid(), m_ready(), m_occ(), m_data());
            end
            checks++;
        end
        issue_valid = 1'b0;
        if (nacc != 4 || issue_ready !== 1'b0 || occupancy !== OW'(4)) begin
            errors++;
            $display("FAIL bp_full: got accepted=%0d r=%0b occ=%0d, want accepted=4 r=0 occ=4",
                     nacc, issue_ready, occupancy);
        end
        checks++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tag = unmask(out_data)[7:0] ^ c_AFF;
            if (out_valid !== 1'b1 || tag !== 8'(i + 1)) begin
                errors++;
                $display("FAIL bp_pop_order %0d: got v=%0b tag=%0d, want v=1 tag=%0d", i, out_valid, tag, i + 1);
            end
            checks++;
            tick();
            if (i == 0) begin
                if (issue_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_credit_return: got r=%0b, want r=1", issue_ready);
                end
                checks++;
            end
        end
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            errors++;
            $display("FAIL bp_empty: got v=%0b occ=%0d, want v=0 occ=0", out_valid, occupancy);
        end
        checks++;
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int nacc, npop, first_out, maxocc;
        nacc = 0; npop = 0; first_out = -1; maxocc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && npop < 100; i++) begin
            issue_valid = (nacc < 100);
            sb_in = {$urandom, $urandom};
            if (issue_valid && issue_ready === 1'b1) nacc++;
            if (out_valid === 1'b1) begin
                npop++;
                if (first_out < 0) first_out = i;
            end
            if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
            tick();
            if (out_valid !== m_valid() || out_data !== m_data() || issue_ready !== m_ready() || occupancy !== m_occ()) begin
                errors++;
                $display("FAIL stream cycle %0d: got v=%0b r=%0b occ=%0d data=%h, want v=%0b r=%0b occ=%0d data=%h",
                         i, out_valid, issue_ready, occupancy, out_data, m_valid(), m_ready(), m_occ(), m_data());
            end
            checks++;
        end
        issue_valid = 1'b0;
        if (npop != 100 || first_out != L + 1 || maxocc > DEP) begin
            errors++;
            $display("FAIL stream_summary: got outputs=%0d first=%0d maxocc=%0d, want outputs=100 first=%0d maxocc<=%0d",
                     npop, first_out, maxocc, L + 1, DEP);
        end
        checks++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int npop, cyc_budget;
        npop = 0;
        cyc_budget = 0;
        while (npop < 256 && cyc_budget < 5000) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            sb_in       = {$urandom, $urandom};
            if (out_valid === 1'b1 && out_ready) npop++;
            tick();
            cyc_budget++;
            if (out_valid !== m_valid() || out_data !== m_data() || issue_ready !== m_ready() || occupancy !== m_occ()) begin
                errors++;
                $display("FAIL random cycle %0d: got v=%0b r=%0b occ=%0d data=%h, want v=%0b r=%0b occ=%0d data=%h",
                         cyc_budget, out_valid, issue_ready, occupancy, out_data, m_valid(), m_ready(), m_occ(), m_data());
            end
            checks++;
        end
        if (npop != 256) begin
            errors++;
            $display("FAIL random_count: got %0d pops, want 256", npop);
        end
        checks++;
        issue_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < L + DEP + 2; i++) begin
            tick();
            if (out_valid !== m_valid() || out_data !== m_data() || occupancy !== m_occ()) begin
                errors++;
                $display("FAIL random_drain %0d: got v=%0b occ=%0d data=%h, want v=%0b occ=%0d data=%h",
                         i, out_valid, occupancy, out_data, m_valid(), m_occ(), m_data());
            end
            checks++;
        end
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midop();
        out_ready = 1'b0; issue_valid = 1'b1;
        sb_in = {$urandom, $urandom};
        repeat (2) tick();
        issue_valid = 1'b0;
        repeat (L) tick();
        issue_valid = 1'b1;
        repeat (2) tick();
        issue_valid = 1'b0;
        if (occupancy !== m_occ() || out_valid !== 1'b1 || fifo_q.size() != 2 || inflight_q.size() != 2) begin
            errors++;
            $display("FAIL midop_setup: got occ=%0d v=%0b, want occ=%0d v=1", occupancy, out_valid, m_occ());
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (out_valid !== 1'b0 || out_data !== '0 || issue_ready !== 1'b1 || occupancy !== '0) begin
            errors++;
            $display("FAIL midop_reset: got v=%0b r=%0b occ=%0d data=%h, want v=0 r=1 occ=0 data=0",
                     out_valid, issue_ready, occupancy, out_data);
        end
        checks++;
        inflight_q.delete();
        fifo_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            tick();
            if (out_valid !== 1'b0 || occupancy !== '0 || out_data !== '0) begin
                errors++;
                $display("FAIL midop_no_capture %0d: got v=%0b occ=%0d data=%h, want v=0 occ=0 data=0",
                         i, out_valid, occupancy, out_data);
            end
            checks++;
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; sb_in = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
